// File: rtl/signed_divider.sv
// Multi-cycle signed integer divider: restoring shift-subtract on operand magnitudes,
// followed by a sign-fixup step. Fixed latency of WIDTH+1 clocks from accept to done.
module signed_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             zflag,
    output logic             dzflag,
    output logic             ovflag
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_SIGN = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        // The most negative value maps onto itself, which is the correct unsigned magnitude.
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic             ov_q, ov_d;

    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             zflag_q, zflag_d;
    logic             dzflag_q, dzflag_d;
    logic             ovflag_q, ovflag_d;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] trial;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

    always_comb begin
        rem_sh = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        trial  = {1'b0, rem_sh} - {2'b00, dvs_q};

        // With a zero divisor every trial succeeds, so rem_q ends up holding the
        // dividend magnitude and the remainder naturally comes out equal to the dividend.
        q_fin = dz_q ? '0 : (qneg_q ? (~quo_q + WIDTH'(1)) : quo_q);
        r_fin = rneg_q ? (~rem_q[WIDTH-1:0] + WIDTH'(1)) : rem_q[WIDTH-1:0];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        dz_d        = dz_q;
        ov_d        = ov_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        zflag_d     = zflag_q;
        dzflag_d    = dzflag_q;
        ovflag_d    = ovflag_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rem_d   = '0;
                    quo_d   = magnitude(dividend);
                    dvs_d   = magnitude(divisor);
                    qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    rneg_d  = dividend[WIDTH-1];
                    dz_d    = (divisor == '0);
                    ov_d    = (dividend == MOST_NEG) && (divisor == '1);
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!trial[WIDTH+1]) begin
                    rem_d = trial[WIDTH:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh;
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = S_SIGN;
                end
            end
            S_SIGN: begin
                quotient_d  = q_fin;
                remainder_d = r_fin;
                zflag_d     = (q_fin == '0);
                dzflag_d    = dz_q;
                ovflag_d    = ov_q;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            dz_q        <= 1'b0;
            ov_q        <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            zflag_q     <= 1'b0;
            dzflag_q    <= 1'b0;
            ovflag_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            dz_q        <= dz_d;
            ov_q        <= ov_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            zflag_q     <= zflag_d;
            dzflag_q    <= dzflag_d;
            ovflag_q    <= ovflag_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign zflag     = zflag_q;
    assign dzflag    = dzflag_q;
    assign ovflag    = ovflag_q;

endmodule
